// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage IEEE-style floating-point multiplier with global stall
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] operand1,
    input  logic [W-1:0] operand2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic signed [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_MIN = '0;
    localparam logic [EXP_W-1:0]      E_ONES  = '1;
    localparam logic [W-1:0]          QNAN    = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: unpack, classify, exponent sum
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
    logic               sign1_d, spec1_d;
    logic [W-1:0]       sres1_d;
    logic [3:0]         sflg1_d;
    logic signed [EW2-1:0] exp1_d;

    assign {sa, ea, fa} = operand1;
    assign {sb, eb, fb} = operand2;
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);
    assign inf_a  = (ea == E_ONES) && (fa == '0);
    assign inf_b  = (eb == E_ONES) && (fb == '0);
    assign nan_a  = (ea == E_ONES) && (fa != '0);
    assign nan_b  = (eb == E_ONES) && (fb != '0);
    assign snan_a = nan_a && !fa[MAN_W-1];
    assign snan_b = nan_b && !fb[MAN_W-1];
    assign sign1_d = sa ^ sb;
    assign exp1_d  = $signed(EW2'(ea)) + $signed(EW2'(eb)) - BIAS;

    always_comb begin
        spec1_d = 1'b0;
        sres1_d = '0;
        sflg1_d = 4'b0000;
        if (nan_a || nan_b) begin
            spec1_d = 1'b1;
            sres1_d = QNAN;
            sflg1_d = {snan_a || snan_b, 3'b000};
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            spec1_d = 1'b1;
            sres1_d = QNAN;
            sflg1_d = 4'b1000;
        end else if (inf_a || inf_b) begin
            spec1_d = 1'b1;
            sres1_d = {sign1_d, E_ONES, {MAN_W{1'b0}}};
        end else if (zero_a || zero_b) begin
            spec1_d = 1'b1;
            sres1_d = {sign1_d, {(W-1){1'b0}}};
        end
    end

    logic                  v1_q, sign1_q, spec1_q;
    logic [W-1:0]          sres1_q;
    logic [3:0]            sflg1_q;
    logic signed [EW2-1:0] exp1_q;
    logic [MAN_W:0]        ma1_q, mb1_q;

    logic                  v2_q, sign2_q, spec2_q;
    logic [W-1:0]          sres2_q;
    logic [3:0]            sflg2_q;
    logic signed [EW2-1:0] exp2_q;
    logic [PW-1:0]         prod2_q;

    logic                  v3_q;
    logic [W-1:0]          result_q;
    logic [3:0]            flags_q;

    // Stage 3: normalise, round to nearest even, pack
    logic                  top, guard, rbit, sticky, round_up, carry, inexact;
    logic [PW-1:0]         norm;
    logic [MAN_W:0]        kept;
    logic [MAN_W+1:0]      rnd;
    logic [MAN_W-1:0]      frac;
    logic signed [EW2-1:0] exp_f;
    logic [W-1:0]          result_d;
    logic [3:0]            flags_d;

    assign top      = prod2_q[PW-1];
    assign norm     = top ? prod2_q : (prod2_q << 1);
    assign kept     = norm[PW-1:MAN_W+1];
    assign guard    = norm[MAN_W];
    assign rbit     = norm[MAN_W-1];
    assign sticky   = |norm[MAN_W-2:0];
    assign round_up = guard && (rbit || sticky || kept[0]);
    assign rnd      = {1'b0, kept} + {{(MAN_W+1){1'b0}}, round_up};
    assign carry    = rnd[MAN_W+1];
    assign frac     = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    assign exp_f    = exp2_q + $signed({{(EW2-1){1'b0}}, top}) + $signed({{(EW2-1){1'b0}}, carry});
    assign inexact  = guard || rbit || sticky;

    always_comb begin
        result_d = {sign2_q, exp_f[EXP_W-1:0], frac};
        flags_d  = {3'b000, inexact};
        if (spec2_q) begin
            result_d = sres2_q;
            flags_d  = sflg2_q;
        end else if (exp_f >= EXP_MAX) begin
            result_d = {sign2_q, E_ONES, {MAN_W{1'b0}}};
            flags_d  = 4'b0101;
        end else if (exp_f <= EXP_MIN) begin
            result_d = {sign2_q, {(W-1){1'b0}}};
            flags_d  = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (advance) begin
            v1_q     <= in_valid;
            sign1_q  <= sign1_d;
            spec1_q  <= spec1_d;
            sres1_q  <= sres1_d;
            sflg1_q  <= sflg1_d;
            exp1_q   <= exp1_d;
            ma1_q    <= {1'b1, fa};
            mb1_q    <= {1'b1, fb};

            v2_q     <= v1_q;
            sign2_q  <= sign1_q;
            spec2_q  <= spec1_q;
            sres2_q  <= sres1_q;
            sflg2_q  <= sflg1_q;
            exp2_q   <= exp1_q;
            prod2_q  <= PW'(ma1_q) * PW'(mb1_q);

            v3_q     <= v2_q;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = v3_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed self-checking bench for fp_mul_pipe
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    localparam int NV = 19;
    localparam logic [31:0] VA [NV] = '{
        32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h3F800001, 32'h3F800003,
        32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000, 32'h80000000,
        32'h00000001, 32'h7F800001, 32'hFFC00000, 32'hC0000000, 32'h3FFFFFFF,
        32'h7F000000, 32'h7F000000, 32'h00800000, 32'h00800000};
    localparam logic [31:0] VB [NV] = '{
        32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000,
        32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000, 32'h40000000,
        32'h40000000, 32'h3F800000, 32'h3F800000, 32'hC0400000, 32'h3FFFFFFF,
        32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F000000};
    localparam logic [31:0] VR [NV] = '{
        32'h40C00000, 32'h3F800002, 32'h40100000, 32'h3FC00002, 32'h3FC00004,
        32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
        32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h40C00000, 32'h407FFFFE,
        32'h7F000000, 32'h7F800000, 32'h00800000, 32'h00000000};
    localparam logic [3:0] VF [NV] = '{
        4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001,
        4'b0101, 4'b0011, 4'b1000, 4'b0000, 4'b0000,
        4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001,
        4'b0000, 4'b0101, 4'b0000, 4'b0011};

    localparam logic [31:0] B2B_IN  [8] = '{
        32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
        32'hC0C00000, 32'h3F000000, 32'h41200000, 32'h42C80000};
    localparam logic [31:0] B2B_OUT [8] = '{
        32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000,
        32'hC1400000, 32'h3F800000, 32'h41A00000, 32'h43480000};

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] flg, output int lat);
        @(posedge clk); #1;
        operand1  = a;
        operand2  = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        flg = flags;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else n_pass++;
        n_checks++;
        if (flags !== 4'h0) $display("FAIL reset_flags got %b want 0000", flags); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_vectors;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        for (int i = 0; i < NV; i++) begin
            run_op(VA[i], VB[i], res, flg, lat);
            n_checks++;
            if (lat !== 3) $display("FAIL vec%0d latency got %0d want 3", i, lat); else n_pass++;
            n_checks++;
            if (res !== VR[i]) $display("FAIL vec%0d result got %h want %h", i, res, VR[i]); else n_pass++;
            n_checks++;
            if (flg !== VF[i]) $display("FAIL vec%0d flags got %b want %b", i, flg, VF[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int          sent = 0;
        int          got = 0;
        int          stall_cnt = 0;
        int          extra = 0;
        logic        held_valid = 1'b0;
        logic [31:0] held = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            out_ready = !(cyc >= 6 && cyc < 11);
            in_valid  = (sent < 8);
            operand1  = 32'h40000000;
            operand2  = B2B_IN[sent < 8 ? sent : 7];
            #1;
            if (out_valid && !out_ready) begin
                stall_cnt++;
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready cyc%0d got %b want 0", cyc, in_ready); else n_pass++;
                if (held_valid) begin
                    n_checks++;
                    if (result !== held) $display("FAIL b2b_stall_hold cyc%0d got %h want %h", cyc, result, held); else n_pass++;
                end
                held = result;
                held_valid = 1'b1;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (result !== B2B_OUT[got]) $display("FAIL b2b_result%0d got %h want %h", got, result, B2B_OUT[got]); else n_pass++;
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (got !== 8) $display("FAIL b2b_count got %0d want 8", got); else n_pass++;
        n_checks++;
        if (stall_cnt !== 5) $display("FAIL b2b_stall_cycles got %0d want 5", stall_cnt); else n_pass++;
        n_checks++;
        if (extra !== 0) $display("FAIL b2b_duplicate got %0d want 0", extra); else n_pass++;
    endtask

    task automatic test_reset_in_flight;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          stale = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            operand1 = VA[i];
            operand2 = VB[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rif_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL rif_result got %h want 00000000", result); else n_pass++;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) $display("FAIL rif_stale got %0d want 0", stale); else n_pass++;
        run_op(32'h3FC00000, 32'h3FC00000, res, flg, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL rif_latency got %0d want 3", lat); else n_pass++;
        n_checks++;
        if (res !== 32'h40100000) $display("FAIL rif_result_after got %h want 40100000", res); else n_pass++;
        n_checks++;
        if (flg !== 4'b0000) $display("FAIL rif_flags_after got %b want 0000", flg); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
